local_history_predictor: RTL

- Parametrised two-level per-address branch direction predictor for the fetch unit: branch history table (BHT) of local histories plus pattern history table (PHT) of per-set counter vectors.
- Generalises the per-address predictor to configurable fetch/update width, history length, counter width and table depths.
- Adds a sequential init sweep, explicit fetch stall/flush handling, and deterministic write-conflict priority.
- Sits between NextPC (request) and Fetch (response/lane qualifiers); updated from the integer branch-resolution ports.

---
 rtl/local_history_predictor_if.sv | 39 +++
 rtl/local_history_predictor.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/local_history_predictor_if.sv
// Fetch-side bus of the local history predictor.
// Groups the prediction request/response and branch-resolution signals.
//   master : NextPC/Fetch/branch-resolution side (drives requests, lane
//            qualifiers and updates; receives predictions)
//   slave  : the predictor
// Per-lane and per-port fields are packed with lane/port 0 in the LSBs.
interface local_history_predictor_if #(
  parameter int FETCH_WIDTH  = 2,
  parameter int UPDATE_WIDTH = 2,
  parameter int HIST_BITS    = 4
);
  logic                            pred_req;
  logic [31:0]                     pred_pc;
  logic                            pred_stall;
  logic                            pred_flush;
  logic [FETCH_WIDTH-1:0]          lane_btb_hit;
  logic [FETCH_WIDTH-1:0]          lane_is_cond;
  logic                            pred_valid;
  logic [FETCH_WIDTH-1:0]          pred_taken;
  logic [FETCH_WIDTH*HIST_BITS-1:0] pred_hist;
  logic [UPDATE_WIDTH-1:0]         upd_valid;
  logic [UPDATE_WIDTH*32-1:0]      upd_pc;
  logic [UPDATE_WIDTH*HIST_BITS-1:0] upd_hist;
  logic [UPDATE_WIDTH-1:0]         upd_taken;
  logic [UPDATE_WIDTH-1:0]         upd_mispred;
  logic [UPDATE_WIDTH-1:0]         upd_is_cond;

  modport master (
    output pred_req, pred_pc, pred_stall, pred_flush, lane_btb_hit, lane_is_cond,
    output upd_valid, upd_pc, upd_hist, upd_taken, upd_mispred, upd_is_cond,
    input  pred_valid, pred_taken, pred_hist
  );

  modport slave (
    input  pred_req, pred_pc, pred_stall, pred_flush, lane_btb_hit, lane_is_cond,
    input  upd_valid, upd_pc, upd_hist, upd_taken, upd_mispred, upd_is_cond,
    output pred_valid, pred_taken, pred_hist
  );
endinterface

// File: rtl/local_history_predictor.sv
// Two-level per-address branch direction predictor.
// A BHT of local histories selects a counter inside a per-PC PHT set.
// After reset an init sweep clears the BHT and sets every PHT counter to
// weak taken; init_done rises when the sweep completes.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   init_done  : high once the init sweep has completed
//   bus        : slave side of local_history_predictor_if (requests,
//                per-lane response, branch-resolution updates)
//
// state | meaning
// INIT  | sweeping tables, requests and updates ignored
// RUN   | predicting and updating
module local_history_predictor #(
  parameter int FETCH_WIDTH  = 2,
  parameter int UPDATE_WIDTH = 2,
  parameter int BHT_ENTRIES  = 256,
  parameter int PHT_SETS     = 64,
  parameter int HIST_BITS    = 4,
  parameter int CTR_BITS     = 2,
  parameter int PC_LSB       = 2
) (
  input  logic clk,
  input  logic rst,
  output logic init_done,
  local_history_predictor_if.slave bus
);
  localparam int BHT_IDX     = $clog2(BHT_ENTRIES);
  localparam int PHT_IDX     = $clog2(PHT_SETS);
  localparam int REQ_IDX     = (BHT_IDX > PHT_IDX) ? BHT_IDX : PHT_IDX;
  localparam int CTRS        = 1 << HIST_BITS;
  localparam int INIT_CYCLES = (BHT_ENTRIES > PHT_SETS) ? BHT_ENTRIES : PHT_SETS;
  localparam int CNT_W       = $clog2(INIT_CYCLES);
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         state;
  logic [CNT_W-1:0]   sweepCnt;
  logic [REQ_IDX-1:0] reqIdx;
  logic               reqValid;

  logic [HIST_BITS-1:0] bht [BHT_ENTRIES];
  logic [CTR_BITS-1:0]  pht [PHT_SETS][CTRS];

  logic [BHT_IDX-1:0]   laneIdx  [FETCH_WIDTH];
  logic [PHT_IDX-1:0]   laneSet  [FETCH_WIDTH];
  logic [HIST_BITS-1:0] laneHist [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] laneTaken;
  logic [FETCH_WIDTH-1:0] specWe;
  logic                 seenTaken;

  logic [BHT_IDX-1:0]   updIdx     [UPDATE_WIDTH];
  logic [PHT_IDX-1:0]   updSet     [UPDATE_WIDTH];
  logic [HIST_BITS-1:0] updHist    [UPDATE_WIDTH];
  logic [HIST_BITS-1:0] updHistNew [UPDATE_WIDTH];
  logic [CTR_BITS-1:0]  updCtrCur  [UPDATE_WIDTH];
  logic [CTR_BITS-1:0]  updCtrNew  [UPDATE_WIDTH];
  logic [UPDATE_WIDTH-1:0] updCtrWe;
  logic [UPDATE_WIDTH-1:0] updBhtWe;

  // Only the index bits of the PCs are meaningful here.
  logic unusedPcBits;
  assign unusedPcBits = ^{bus.pred_pc, bus.upd_pc};

  assign init_done = (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      sweepCnt <= '0;
      reqIdx   <= '0;
      reqValid <= 1'b0;
    end else if (state == ST_INIT) begin
      sweepCnt <= sweepCnt + 1'b1;
      if (int'(sweepCnt) == INIT_CYCLES - 1) state <= ST_RUN;
    end else if (!bus.pred_stall) begin
      if (bus.pred_req) reqIdx <= bus.pred_pc[PC_LSB +: REQ_IDX];
      reqValid <= bus.pred_req && !bus.pred_flush;
    end
  end

  // Lane i PC is base + i words, so its index is the base index plus i.
  always_comb begin
    laneTaken = '0;
    specWe    = '0;
    seenTaken = 1'b0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      laneIdx[i]   = reqIdx[BHT_IDX-1:0] + BHT_IDX'(i);
      laneSet[i]   = reqIdx[PHT_IDX-1:0] + PHT_IDX'(i);
      laneHist[i]  = bht[laneIdx[i]];
      laneTaken[i] = !seenTaken && bus.lane_btb_hit[i]
                     && pht[laneSet[i]][laneHist[i]][CTR_BITS-1];
      specWe[i]    = (state == ST_RUN) && reqValid && !bus.pred_stall && !bus.pred_flush
                     && bus.lane_btb_hit[i] && bus.lane_is_cond[i] && !seenTaken;
      seenTaken    = seenTaken | laneTaken[i];
    end
  end

  always_comb begin
    bus.pred_valid = reqValid;
    bus.pred_taken = reqValid ? laneTaken : '0;
    bus.pred_hist  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++)
      bus.pred_hist[i*HIST_BITS +: HIST_BITS] = reqValid ? laneHist[i] : '0;
  end

  always_comb begin
    for (int j = 0; j < UPDATE_WIDTH; j++) begin
      updIdx[j]     = bus.upd_pc[j*32 + PC_LSB +: BHT_IDX];
      updSet[j]     = bus.upd_pc[j*32 + PC_LSB +: PHT_IDX];
      updHist[j]    = bus.upd_hist[j*HIST_BITS +: HIST_BITS];
      updHistNew[j] = (updHist[j] << 1) | HIST_BITS'(bus.upd_taken[j]);
      updCtrCur[j]  = pht[updSet[j]][updHist[j]];
      if (bus.upd_taken[j])
        updCtrNew[j] = (updCtrCur[j] == CTR_MAX) ? updCtrCur[j] : updCtrCur[j] + 1'b1;
      else
        updCtrNew[j] = (updCtrCur[j] == '0) ? updCtrCur[j] : updCtrCur[j] - 1'b1;
      updCtrWe[j] = (state == ST_RUN) && bus.upd_valid[j] && bus.upd_is_cond[j];
      updBhtWe[j] = updCtrWe[j] && bus.upd_mispred[j];
    end
  end

  // Write order sets priority: later assignments win, so speculative writes
  // go first and update ports run from highest to port 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        if (int'(sweepCnt) < BHT_ENTRIES) bht[sweepCnt[BHT_IDX-1:0]] <= '0;
        if (int'(sweepCnt) < PHT_SETS)
          for (int k = 0; k < CTRS; k++) pht[sweepCnt[PHT_IDX-1:0]][k] <= CTR_WEAK;
      end else begin
        for (int i = 0; i < FETCH_WIDTH; i++)
          if (specWe[i]) bht[laneIdx[i]] <= (laneHist[i] << 1) | HIST_BITS'(laneTaken[i]);
        for (int j = UPDATE_WIDTH - 1; j >= 0; j--) begin
          if (updCtrWe[j]) pht[updSet[j]][updHist[j]] <= updCtrNew[j];
          if (updBhtWe[j]) bht[updIdx[j]] <= updHistNew[j];
        end
      end
    end
  end
endmodule
